micro_sched: RTL and testbench
==============================

# micro_sched

Round-robin scheduler that shares the micro-op decoder between two requesters. It accepts 4-bit micro-op codes, arbitrates fairly between the requesters, and classifies each granted code as A, L, B or NOP. It then drives the decoder's enable and code inputs for a class-dependent number of cycles and signals completion back to the owner. It sits between the instruction sources and the decoder and is the only block that drives decoder enable.

## Interface
- A_CYCLES, 2: execute cycles for A-class codes (1..7; 0 treated as 1)
- L_CYCLES, 3: execute cycles for L-class codes (1..7; 0 treated as 1)
- B_CYCLES, 1: execute cycles for B-class codes (1..7; 0 treated as 1)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - i_clk  in  1: clock; all state changes on the rising edge
  - i_rst  in  1: synchronous reset, active-high
- Requesters:
  - i_req  in  2: request, bit n = requester n
  - i_code0  in  4: requester 0 code
  - i_code1  in  4: requester 1 code
- Outputs to requesters:
  - o_gnt  out  2: one-hot grant pulse
  - o_done  out  2: one-hot completion pulse to owner
- Outputs to the decoder:
  - o_en  out  1: decoder enable
  - o_code  out  4: code presented to decoder
  - o_cls  out  2: class of current op: 00 NOP, 01 A, 10 L, 11 B
- Status:
  - o_busy  out  1: high whenever state is not IDLE

## Operation
- Classification:
  - A: 1010, 1011, 1100.
  - L: 0011, 0100, 0010, 1110.
  - B: 1111.
  - NOP: all other codes.
  - Execute length N: A_CYCLES, L_CYCLES or B_CYCLES by class; NOP = 1.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Any i_req bit set: choose winner, capture its code, class and N, assert o_gnt[winner] next cycle, go to EXEC.
  - No request: stay in IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the requester not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates on entry to DONE.
- EXEC:
  - o_en=1, o_code=captured code, o_cls=captured class for exactly N cycles.
  - A 3-bit down-counter is loaded with N; EXEC exits to DONE when it reaches 1.
- DONE:
  - Lasts one cycle: o_done[owner]=1, o_en=0, o_code=0, o_cls=00.
  - Next state is IDLE.
- Request handshake:
  - A requester holds i_req high and its code stable until it sees o_gnt.
  - The code is captured in the IDLE cycle that sampled the request.
  - Code changes after capture have no effect.
  - i_req still high after o_done counts as a new request.
  - Dropping i_req before a grant withdraws the request with no side effects.
- Requests arriving while busy are not queued; they are sampled only in IDLE.
- Reset (any state, including mid-EXEC):
  - Next cycle: state IDLE, o_gnt=00, o_done=00, o_en=0, o_code=0000, o_cls=00, o_busy=0, counter=0, last-served pointer=1.
  - An aborted op never produces o_done.

## Timing
- All outputs are registered; none is combinational from inputs.
- Latency, with the request sampled in IDLE at cycle t:
  - o_gnt high in cycle t+1 only.
  - o_en high in cycles t+1 .. t+N.
  - o_done high in cycle t+N+1.
  - IDLE again in cycle t+N+2.
- Back-to-back ops: the earliest next grant is cycle t+N+3, so throughput is one op per N+2 cycles.
- o_busy is high from t+1 through t+N+1.
- o_gnt and o_done are never both high in the same cycle.
- At most one bit of o_gnt, and at most one bit of o_done, is high in any cycle.
- o_cls and o_code are stable for the whole o_en window.

## Test plan
- Reset: assert i_rst 2 cycles with i_req=11 -> all outputs 0 during reset. First grant after release is o_gnt=01.
- Single A op, defaults: i_req=01, i_code0=1010 at t -> o_gnt=01 @t+1; o_en=1, o_code=1010, o_cls=01 @t+1..t+2; o_done=01 @t+3; o_busy=0 @t+4.
- Fairness: i_req=11 held continuously, i_code0=1111, i_code1=0010 -> grants alternate 01, 10, 01, 10. Each B window is 1 cycle with o_cls=11; each L window is 3 cycles with o_cls=10.
- NOP and parameter override: A_CYCLES=4, i_code1=0000 -> o_en 1 cycle with o_cls=00. Then i_code1=1011 -> o_en 4 cycles with o_cls=01.
- Withdrawal and late change: i_req=01 during requester 1's EXEC, dropped before IDLE -> no grant to 0. i_code1 changed after grant -> o_code keeps the captured value.
- Reset mid-EXEC: assert i_rst in the 2nd cycle of a 3-cycle L op -> next cycle o_en=0, o_busy=0, no o_done. With i_req=11 afterwards -> o_gnt=01.

Source files
------------

// File: rtl/micro_sched.sv
// micro_sched: round-robin arbiter between two micro-op requesters that drives
// the shared decoder for a class-dependent number of cycles.
module micro_sched #(
    parameter int A_CYCLES = 2,
    parameter int L_CYCLES = 3,
    parameter int B_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic [3:0] i_code0,
    input  logic [3:0] i_code1,
    output logic [1:0] o_gnt,
    output logic [1:0] o_done,
    output logic       o_en,
    output logic [3:0] o_code,
    output logic [1:0] o_cls,
    output logic       o_busy,
    output logic [1:0] o_state
);

    localparam logic [1:0] CLS_NOP = 2'b00;
    localparam logic [1:0] CLS_A   = 2'b01;
    localparam logic [1:0] CLS_L   = 2'b10;
    localparam logic [1:0] CLS_B   = 2'b11;

    function automatic logic [2:0] clamp_len(input int cycles);
        if (cycles <= 0) return 3'd1;
        if (cycles > 7)  return 3'd7;
        return 3'(cycles);
    endfunction

    localparam logic [2:0] A_LEN = clamp_len(A_CYCLES);
    localparam logic [2:0] L_LEN = clamp_len(L_CYCLES);
    localparam logic [2:0] B_LEN = clamp_len(B_CYCLES);

    function automatic logic [1:0] classify(input logic [3:0] code);
        case (code)
            4'b1010, 4'b1011, 4'b1100:          return CLS_A;
            4'b0011, 4'b0100, 4'b0010, 4'b1110: return CLS_L;
            4'b1111:                            return CLS_B;
            default:                            return CLS_NOP;
        endcase
    endfunction

    function automatic logic [2:0] len_of(input logic [1:0] cls);
        case (cls)
            CLS_A:   return A_LEN;
            CLS_L:   return L_LEN;
            CLS_B:   return B_LEN;
            default: return 3'd1;
        endcase
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       owner;
    logic       last_served;
    logic [3:0] code_q;
    logic [1:0] cls_q;
    logic [2:0] cnt;

    logic       win;
    logic [3:0] win_code;
    logic [1:0] win_cls;
    logic [2:0] win_len;

    logic [1:0] gnt_next;
    logic [1:0] done_next;
    logic       en_next;
    logic [3:0] code_next;
    logic [1:0] cls_next;
    logic       busy_next;

    // Handshake: a requester holds i_req[n] and its code until it sees o_gnt[n];
    // requests are only sampled in IDLE, and the code is captured in that cycle.
    always_comb begin
        win = 1'b0;
        case (i_req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_served;
            default: win = 1'b0;
        endcase
        win_code = win ? i_code1 : i_code0;
        win_cls  = classify(win_code);
        win_len  = len_of(win_cls);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (|i_req) state_next = ST_EXEC;
            ST_EXEC: if (cnt <= 3'd1) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, so nothing reaches a port combinationally.
    always_comb begin
        gnt_next  = 2'b00;
        done_next = 2'b00;
        en_next   = 1'b0;
        code_next = 4'b0000;
        cls_next  = CLS_NOP;
        busy_next = (state_next != ST_IDLE);
        if (state_next == ST_EXEC) begin
            en_next = 1'b1;
            if (state == ST_IDLE) begin
                gnt_next  = win ? 2'b10 : 2'b01;
                code_next = win_code;
                cls_next  = win_cls;
            end else begin
                code_next = code_q;
                cls_next  = cls_q;
            end
        end
        if (state_next == ST_DONE) begin
            done_next = owner ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            code_q      <= 4'b0000;
            cls_q       <= CLS_NOP;
            cnt         <= 3'd0;
            o_gnt       <= 2'b00;
            o_done      <= 2'b00;
            o_en        <= 1'b0;
            o_code      <= 4'b0000;
            o_cls       <= CLS_NOP;
            o_busy      <= 1'b0;
        end else begin
            state  <= state_next;
            o_gnt  <= gnt_next;
            o_done <= done_next;
            o_en   <= en_next;
            o_code <= code_next;
            o_cls  <= cls_next;
            o_busy <= busy_next;
            if (state == ST_IDLE && (|i_req)) begin
                owner  <= win;
                code_q <= win_code;
                cls_q  <= win_cls;
                cnt    <= win_len;
            end
            if (state == ST_EXEC) begin
                if (cnt > 3'd1) begin
                    cnt <= cnt - 3'd1;
                end else begin
                    // Fairness pointer moves only when an op actually completes.
                    last_served <= owner;
                    cnt         <= 3'd0;
                end
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_micro_sched.sv
// Directed bench for micro_sched: cycle vector table plus hand-written
// sequences for parameter override, withdrawal and reset mid-op.
module tb_micro_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [3:0] code0 = 4'b0000;
    logic [3:0] code1 = 4'b0000;

    logic [1:0] gnt, done, cls, st;
    logic       en, busy;
    logic [3:0] code;

    logic [1:0] gnt4, done4, cls4, st4;
    logic       en4, busy4;
    logic [3:0] code4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    micro_sched dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_code0(code0), .i_code1(code1),
        .o_gnt(gnt), .o_done(done), .o_en(en), .o_code(code), .o_cls(cls),
        .o_busy(busy), .o_state(st)
    );

    micro_sched #(.A_CYCLES(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_code0(code0), .i_code1(code1),
        .o_gnt(gnt4), .o_done(done4), .o_en(en4), .o_code(code4), .o_cls(cls4),
        .o_busy(busy4), .o_state(st4)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [3:0] c0;
        logic [3:0] c1;
        logic [1:0] gnt;
        logic [1:0] done;
        logic       en;
        logic [3:0] code;
        logic [1:0] cls;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [1:0] rq, input logic [3:0] c0,
                           input logic [3:0] c1, input logic [1:0] g, input logic [1:0] d,
                           input logic e, input logic [3:0] cd, input logic [1:0] cl,
                           input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.c0 = c0; v.c1 = c1;
        v.gnt = g; v.done = d; v.en = e; v.code = cd; v.cls = cl; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op on the A_CYCLES=4 instance; caller sets req/code1 while it is idle.
    task automatic exec4(input string name, input int exp_n, input logic [1:0] exp_cls,
                         input logic [3:0] exp_code);
        int n_en   = 0;
        int n_done = 0;
        int n_bad  = 0;
        tick();
        check({name, "_gnt"}, 32'(gnt4), 32'(2'b10));
        req = 2'b00;
        for (int i = 0; i < 12; i++) begin
            if (en4) begin
                n_en++;
                if (cls4 !== exp_cls || code4 !== exp_code) n_bad++;
            end
            if (done4 === 2'b10) n_done++;
            tick();
        end
        check({name, "_len"}, 32'(n_en), 32'(exp_n));
        check({name, "_window"}, 32'(n_bad), 32'd0);
        check({name, "_done"}, 32'(n_done), 32'd1);
    endtask

    initial begin
        logic [13:0] exp_v;
        logic [13:0] act_v;
        logic [1:0]  exp_st;

        // rst req  c0       c1       gnt    done   en code     cls    busy
        add_vec(1, 2'b11, 4'b1010, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);
        add_vec(1, 2'b11, 4'b1010, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);
        add_vec(0, 2'b11, 4'b1010, 4'b0010, 2'b01, 2'b00, 1, 4'b1010, 2'b01, 1);
        add_vec(0, 2'b10, 4'b1010, 4'b0010, 2'b00, 2'b00, 1, 4'b1010, 2'b01, 1);
        add_vec(0, 2'b10, 4'b1010, 4'b0010, 2'b00, 2'b01, 0, 4'b0000, 2'b00, 1);
        add_vec(0, 2'b10, 4'b1010, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);
        add_vec(0, 2'b10, 4'b1010, 4'b0010, 2'b10, 2'b00, 1, 4'b0010, 2'b10, 1);
        // fairness: both requesting continuously, B on 0 and L on 1
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b00, 1, 4'b0010, 2'b10, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b00, 1, 4'b0010, 2'b10, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b10, 0, 4'b0000, 2'b00, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b01, 2'b00, 1, 4'b1111, 2'b11, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b01, 0, 4'b0000, 2'b00, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b10, 2'b00, 1, 4'b0010, 2'b10, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b00, 1, 4'b0010, 2'b10, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b00, 1, 4'b0010, 2'b10, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b10, 0, 4'b0000, 2'b00, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b01, 2'b00, 1, 4'b1111, 2'b11, 1);
        add_vec(0, 2'b11, 4'b1111, 4'b0010, 2'b00, 2'b01, 0, 4'b0000, 2'b00, 1);
        add_vec(0, 2'b00, 4'b1111, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);
        add_vec(0, 2'b00, 4'b1111, 4'b0010, 2'b00, 2'b00, 0, 4'b0000, 2'b00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst   = vecs[i].rst;
            req   = vecs[i].req;
            code0 = vecs[i].c0;
            code1 = vecs[i].c1;
            tick();
            exp_st = vecs[i].en ? 2'd1 : ((vecs[i].done != 2'b00) ? 2'd2 : 2'd0);
            exp_v  = {vecs[i].gnt, vecs[i].done, vecs[i].en, vecs[i].code,
                      vecs[i].cls, vecs[i].busy, exp_st};
            act_v  = {gnt, done, en, code, cls, busy, st};
            check($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
        end

        // NOP and A_CYCLES override on the second instance
        rst = 1'b1; req = 2'b00;
        tick();
        rst = 1'b0;
        req = 2'b10; code1 = 4'b0000;
        exec4("nop4", 1, 2'b00, 4'b0000);
        req = 2'b10; code1 = 4'b1011;
        exec4("a4", 4, 2'b01, 4'b1011);

        // withdrawal of requester 0 during EXEC, late change of code1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b10; code0 = 4'b0000; code1 = 4'b0010;
        tick();
        check("wd_gnt", 32'(gnt), 32'(2'b10));
        check("wd_code0", 32'(code), 32'(4'b0010));
        req = 2'b01; code1 = 4'b1111;
        tick();
        check("wd_code1", 32'({en, code}), 32'({1'b1, 4'b0010}));
        tick();
        check("wd_code2", 32'({en, code, cls}), 32'({1'b1, 4'b0010, 2'b10}));
        req = 2'b00;
        tick();
        check("wd_done", 32'(done), 32'(2'b10));
        tick();
        check("wd_idle", 32'({busy, st}), 32'd0);
        tick();
        check("wd_no_gnt", 32'({gnt, busy}), 32'd0);

        // serve requester 0 so the pointer points at it before the abort
        req = 2'b01; code0 = 4'b1111;
        tick();
        check("pre_gnt", 32'(gnt), 32'(2'b01));
        req = 2'b00;
        tick();
        check("pre_done", 32'(done), 32'(2'b01));
        tick();

        // reset in the second cycle of a 3-cycle L op
        req = 2'b10; code1 = 4'b0010;
        tick();
        check("ab_gnt", 32'(gnt), 32'(2'b10));
        req = 2'b00;
        tick();
        check("ab_exec2", 32'({en, cls}), 32'({1'b1, 2'b10}));
        rst = 1'b1;
        tick();
        check("rst_mid", 32'({gnt, done, en, code, cls, busy, st}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_no_done%0d", i), 32'({done, busy}), 32'd0);
        end
        req = 2'b11; code0 = 4'b1010; code1 = 4'b0010;
        tick();
        check("rst_ptr", 32'(gnt), 32'(2'b01));
        req = 2'b00;
        for (int i = 0; i < 5; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
